// File: rtl/picture_col_ctr_pkg.sv
// rtl/picture_col_ctr_pkg.sv - shared widths, state encoding and blank-column helper for picture_col_ctr
package picture_col_ctr_pkg;

    localparam int ROW_W = 3;
    localparam int COL_W = 8;
    localparam logic [ROW_W-1:0] LAST_ROW = 3'd7;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // The blank pattern doubles as the XOR mask applied to every lit pattern.
    function automatic logic [COL_W-1:0] blank_col(input bit active_low);
        return active_low ? {COL_W{1'b1}} : {COL_W{1'b0}};
    endfunction

endpackage

// File: rtl/picture_frame_buf.sv
// rtl/picture_frame_buf.sv - 8x8 double buffer with back write port, bulk swap and front read port
module picture_frame_buf
    import picture_col_ctr_pkg::*;
#(
    parameter int ROWS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_addr,
    input  logic [COL_W-1:0] wr_data,
    input  logic             swap,
    input  logic [ROW_W-1:0] rd_addr,
    output logic [COL_W-1:0] rd_data
);

    logic [COL_W-1:0] back  [ROWS];
    logic [COL_W-1:0] front [ROWS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                back[i]  <= '0;
                front[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                back[wr_addr] <= wr_data;
            end
            // Back keeps its contents after the copy so edits can be incremental.
            if (swap) begin
                for (int i = 0; i < ROWS; i++) begin
                    front[i] <= back[i];
                end
            end
        end
    end

    assign rd_data = front[rd_addr];

endmodule

// File: rtl/picture_col_ctr.sv
// rtl/picture_col_ctr.sv - column driver for the 8x8 dot matrix with tear-free frame commit
module picture_col_ctr
    import picture_col_ctr_pkg::*;
#(
    parameter bit COL_ACTIVE_LOW = 1'b0,
    parameter int ROWS           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] sw,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_addr,
    input  logic [COL_W-1:0] wr_data,
    output logic             wr_ready,
    input  logic             commit,
    output logic             swap_done,
    output logic [COL_W-1:0] col,
    output logic             seq_err
);

    localparam logic [COL_W-1:0] BLANK = blank_col(COL_ACTIVE_LOW);

    state_t           state;
    state_t           state_n;
    logic             buf_wr;
    logic             swap;
    logic [COL_W-1:0] front_row;
    logic [ROW_W-1:0] prev_sw;
    logic [ROW_W-1:0] exp_sw;
    logic             armed;

    picture_frame_buf #(
        .ROWS(ROWS)
    ) u_frame_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (buf_wr),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .swap   (swap),
        .rd_addr(sw),
        .rd_data(front_row)
    );

    always_comb begin
        state_n  = state;
        wr_ready = 1'b0;
        buf_wr   = 1'b0;
        swap     = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                buf_wr   = wr_en;
                if (commit) begin
                    state_n = PENDING;
                end
            end
            PENDING: begin
                // Swapping on the last row means the new front is first read at row 0.
                if (sw == LAST_ROW) begin
                    swap    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign exp_sw = prev_sw + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col       <= BLANK;
            swap_done <= 1'b0;
            seq_err   <= 1'b0;
            armed     <= 1'b0;
            prev_sw   <= '0;
        end else begin
            state     <= state_n;
            col       <= front_row ^ BLANK;
            swap_done <= swap;
            armed     <= 1'b1;
            prev_sw   <= sw;
            seq_err   <= armed && (sw != exp_sw);
        end
    end

endmodule

// File: tb/tb_picture_col_ctr.sv
// tb/tb_picture_col_ctr.sv - directed self-checking bench for picture_col_ctr
module tb_picture_col_ctr;

    logic       clk;
    logic       rst;
    logic [2:0] sw;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       wr_ready,   swap_done,   seq_err;
    logic [7:0] col;
    logic       wr_ready_b, swap_done_b, seq_err_b;
    logic [7:0] col_b;

    picture_col_ctr #(.COL_ACTIVE_LOW(1'b0), .ROWS(8)) dut (
        .clk(clk), .rst(rst), .sw(sw), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .commit(commit),
        .swap_done(swap_done), .col(col), .seq_err(seq_err)
    );

    picture_col_ctr #(.COL_ACTIVE_LOW(1'b1), .ROWS(8)) dut_b (
        .clk(clk), .rst(rst), .sw(sw), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready_b), .commit(commit),
        .swap_done(swap_done_b), .col(col_b), .seq_err(seq_err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         total;
    int         fails;
    logic [2:0] cur_sw;
    logic [2:0] last_sw;
    logic [7:0] ef [8];
    logic       seen;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        sw = cur_sw;
        @(posedge clk);
        #1;
        last_sw = cur_sw;
        cur_sw  = cur_sw + 3'd1;
    endtask

    initial begin
        total = 0; fails = 0;
        cur_sw = 3'd0; last_sw = 3'd0;
        rst = 1'b1; sw = 3'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; commit = 1'b0;
        for (int i = 0; i < 8; i++) ef[i] = 8'h00;

        // reset state
        step(); step();
        chk("rst_col", col, 8'h00);
        chk("rst_col_b", col_b, 8'hFF);
        chk("rst_wr_ready", {7'd0, wr_ready}, 8'd1);
        chk("rst_swap_done", {7'd0, swap_done}, 8'd0);
        chk("rst_seq_err", {7'd0, seq_err}, 8'd0);
        rst = 1'b0;

        // 1: free-running rows, blank frame
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t1_col", col, 8'h00);
            chk("t1_seq_err", {7'd0, seq_err}, 8'd0);
            chk("t1_wr_ready", {7'd0, wr_ready}, 8'd1);
        end

        // 2: walking-one frame, commit at sw=2
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_addr = 3'(r); wr_data = 8'h01 << r;
            step();
        end
        wr_en = 1'b0;
        while (cur_sw != 3'd2) step();
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("t2_wr_ready_pending", {7'd0, wr_ready}, 8'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t2_swap_done", {7'd0, swap_done}, (k == 5) ? 8'd1 : 8'd0);
        end
        chk("t2_col_old_row7", col, 8'h00);
        for (int r = 0; r < 8; r++) ef[r] = 8'h01 << r;
        for (int r = 0; r < 8; r++) begin
            step();
            chk("t2_col", col, ef[last_sw]);
            chk("t2_col_b", col_b, ~ef[last_sw]);
            chk("t2_swap_done_off", {7'd0, swap_done}, 8'd0);
        end

        // 3: commit on sw=7 waits a full frame; writes and commits while pending are dropped
        while (cur_sw != 3'd7) step();
        commit = 1'b1;
        step();
        chk("t3_wr_ready_pending", {7'd0, wr_ready}, 8'd0);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA;
        step();
        chk("t3_swap_done_1", {7'd0, swap_done}, 8'd0);
        wr_en = 1'b0; commit = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            step();
            chk("t3_swap_done", {7'd0, swap_done}, (k == 8) ? 8'd1 : 8'd0);
        end
        step();
        chk("t3_row0_kept", col, 8'h01);
        chk("t3_no_second_swap", {7'd0, swap_done}, 8'd0);
        chk("t3_wr_ready_idle", {7'd0, wr_ready}, 8'd1);

        // 4: active-low columns with row 3 = 0F
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h0F;
        step();
        wr_en = 1'b0;
        ef[3] = 8'h0F;
        commit = 1'b1;
        step();
        commit = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            seen = swap_done;
        end
        chk("t4_swap_seen", {7'd0, seen}, 8'd1);
        while (cur_sw != 3'd3) step();
        step();
        chk("t4_col_b_row3", col_b, 8'hF0);
        chk("t4_col_row3", col, 8'h0F);

        // 6: broken row sequence 0,1,2,5,6
        while (cur_sw != 3'd0) step();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: cur_sw = 3'd0;
                1: cur_sw = 3'd1;
                2: cur_sw = 3'd2;
                3: cur_sw = 3'd5;
                default: cur_sw = 3'd6;
            endcase
            step();
            chk("t6_seq_err", {7'd0, seq_err}, (last_sw == 3'd5) ? 8'd1 : 8'd0);
            chk("t6_col", col, ef[last_sw]);
        end
        step();
        chk("t6_seq_err_after", {7'd0, seq_err}, 8'd0);

        // 5: reset while pending loses the commit and clears the frame
        while (cur_sw != 3'd1) step();
        commit = 1'b1;
        step();
        commit = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_wr_ready", {7'd0, wr_ready}, 8'd1);
        chk("t5_col", col, 8'h00);
        chk("t5_col_b", col_b, 8'hFF);
        chk("t5_swap_done", {7'd0, swap_done}, 8'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t5_no_swap", {7'd0, swap_done}, 8'd0);
            chk("t5_col_blank", col, 8'h00);
            chk("t5_seq_err", {7'd0, seq_err}, 8'd0);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/picture_col_ctr.md
Name: picture_col_ctr

Overview:
Column-side driver for the 8x8 dot-matrix display, paired with the row scanner, which outputs a row index `sw` (0..7, +1 per clk, wraps) and a registered active-low row strobe. This block holds a double-buffered 8x8 frame and outputs the column pattern for the row currently strobed. Upstream logic writes the back buffer, then commits it. The swap happens only at a frame boundary, so a displayed frame never tears.

Parameters:
COL_ACTIVE_LOW, 0, 1 = column bit 0 lights the LED (output inverted); 0 = column bit 1 lights it.
ROWS, 8, row count; fixed at 8 and must match the 3-bit scan index.

Ports:
clk  in  1  system clock, same clock as the row scanner
rst  in  1  synchronous, active-high reset
sw  in  3  current row index from the row scanner
wr_en  in  1  back-buffer write strobe
wr_addr  in  3  back-buffer row address
wr_data  in  8  pixel bits for that row; bit n = column n, 1 = lit
wr_ready  out  1  high when writes and commit are accepted
commit  in  1  request to swap the back buffer to the front at the next frame boundary
swap_done  out  1  one-cycle pulse on the cycle the swap takes effect
col  out  8  column drive for the row being strobed
seq_err  out  1  one-cycle pulse when `sw` breaks the +1 mod 8 sequence

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. All state is updated on posedge clk only.
- Reset values:
  - both buffers all 0;
  - col = blank (8'h00, or 8'hFF when COL_ACTIVE_LOW = 1);
  - wr_ready = 1; swap_done = 0; seq_err = 0;
  - state = IDLE; sequence checker disarmed.
- Column output:
  - col is registered: col(t+1) = front[sw(t)], XOR all-ones when COL_ACTIVE_LOW = 1.
  - This is exactly one cycle of latency, matching the scanner's registered row strobe, so col and row change on the same edge.
- State machine:
  - IDLE: wr_ready = 1. When wr_en = 1, back[wr_addr] <= wr_data. When commit = 1, go to PENDING; a write in the same cycle is included in the committed frame.
  - PENDING: wr_ready = 0. wr_en and commit are ignored (writes dropped, no error). On a cycle with sw == 3'd7: copy back to front (all 8 rows, in one cycle), pulse swap_done next cycle, return to IDLE.
  - The first col value taken from the new front is for sw = 0, so every displayed frame starts at row 0.
- Boundary cases:
  - Commit on a cycle where sw == 7: enter PENDING; the swap waits for the next sw == 7 (8 cycles later). The current boundary is never used.
  - Commit while PENDING: ignored, no second swap.
  - The back buffer keeps its contents after a swap, so incremental edits are possible.
  - rst while PENDING: return to IDLE, the commit is lost, both buffers clear, col blanks on the next cycle.
- Sequence checker:
  - Armed after the first post-reset cycle.
  - Compares sw to prev_sw + 1 (3-bit wrap); a mismatch pulses seq_err one cycle later.
  - Display and swap behaviour are unaffected by a mismatch.
- Width rules: all row arithmetic is 3-bit modulo 8; there are no X or undefined row indices.

Decomposition:
- Shared package: ROW_W = 3, COL_W = 8, LAST_ROW = 3'd7, the state encoding (IDLE, PENDING), and the BLANK constant derived from COL_ACTIVE_LOW.
- One natural sub-module: picture_frame_buf, the 8x8 double buffer with back write port, bulk swap and front read port.
- The FSM, column register and sequence checker stay in the top level.

Test Plan:
1. Reset then free-running sw 0..7 -> col = 8'h00 for every row; wr_ready = 1; no seq_err after the first wrap.
2. Write row r = 8'h01 << r for r = 0..7; commit at sw = 2 -> swap_done pulses after the sw = 7 cycle; the following cycles show col = 01, 02, 04 .. 80, aligned with row strobes FE, FD .. 7F.
3. Commit exactly at sw = 7 -> no swap at that boundary; swap_done 9 cycles after commit; wr_en during PENDING (row 0 = 8'hAA) leaves back[0] unchanged.
4. COL_ACTIVE_LOW = 1 with front row 3 = 8'h0F -> col = 8'hF0 when sw = 3 was presented the previous cycle; blank = 8'hFF after reset.
5. Assert rst while PENDING -> next cycle state IDLE, wr_ready = 1, col = blank, no swap_done ever.
6. Drive sw 0, 1, 2, 5, 6 -> exactly one seq_err pulse, the cycle after sw = 5 is sampled; col keeps tracking sw.
